// File: rtl/sram_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_master
// Brief    : Single-transaction asynchronous SRAM bus master with programmable
//            setup / strobe / hold timing; all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bus_master #(
    parameter int DW         = 15,
    parameter int AW         = 11,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          rnw,
    input  logic [AW:0]   req_addr,
    input  logic [DW:0]   req_wdata,
    output logic          busy,
    output logic          done,
    output logic [DW:0]   rdata,
    output logic [AW:0]   addr,
    output logic [DW:0]   data_out,
    output logic          data_oe,
    input  logic [DW:0]   data_in,
    output logic          ncs,
    output logic          nwe,
    output logic          noe
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam logic [3:0] C_SETUP  = 4'(SETUP_CYC);
    localparam logic [3:0] C_STROBE = 4'(STROBE_CYC);
    localparam logic [3:0] C_HOLD   = 4'(HOLD_CYC);

    logic [1:0]  state_q,    state_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic        rnw_q,      rnw_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic [DW:0] rdata_q,    rdata_d;
    logic [AW:0] addr_q,     addr_d;
    logic [DW:0] data_out_q, data_out_d;
    logic        data_oe_q,  data_oe_d;
    logic        ncs_q,      ncs_d;
    logic        nwe_q,      nwe_d;
    logic        noe_q,      noe_d;

    logic        last_cyc;
    assign last_cyc = (cnt_q == 4'd1);

    // Output values for the next state are computed here so every pin comes
    // straight from a flop and changes exactly once per state transition.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rnw_d      = rnw_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        data_out_d = data_out_q;
        data_oe_d  = data_oe_q;
        ncs_d      = ncs_q;
        nwe_d      = nwe_q;
        noe_d      = noe_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d    = S_SETUP;
                    cnt_d      = C_SETUP;
                    rnw_d      = rnw;
                    addr_d     = req_addr;
                    data_out_d = req_wdata;
                    data_oe_d  = ~rnw;
                    ncs_d      = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_SETUP: begin
                if (last_cyc) begin
                    state_d = S_STROBE;
                    cnt_d   = C_STROBE;
                    nwe_d   = rnw_q;
                    noe_d   = ~rnw_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_STROBE: begin
                if (last_cyc) begin
                    state_d = S_HOLD;
                    cnt_d   = C_HOLD;
                    nwe_d   = 1'b1;
                    noe_d   = 1'b1;
                    if (rnw_q) begin
                        rdata_d = data_in;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (last_cyc) begin
                    state_d   = S_IDLE;
                    cnt_d     = 4'd0;
                    ncs_d     = 1'b1;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                cnt_d     = 4'd0;
                ncs_d     = 1'b1;
                nwe_d     = 1'b1;
                noe_d     = 1'b1;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            rnw_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            addr_q     <= '0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
            ncs_q      <= 1'b1;
            nwe_q      <= 1'b1;
            noe_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rnw_q      <= rnw_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            ncs_q      <= ncs_d;
            nwe_q      <= nwe_d;
            noe_q      <= noe_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign addr     = addr_q;
    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign ncs      = ncs_q;
    assign nwe      = nwe_q;
    assign noe      = noe_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bus_master
// Brief    : Directed bench for sram_bus_master (default timing and 2/1/3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bus_master;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        req = 1'b0, rnw = 1'b0;
    logic [11:0] req_addr = '0;
    logic [15:0] req_wdata = '0, data_in = '0;
    logic        busy, done, data_oe, ncs, nwe, noe;
    logic [15:0] rdata, data_out;
    logic [11:0] addr;

    logic        b_req = 1'b0, b_rnw = 1'b0;
    logic [11:0] b_req_addr = '0;
    logic [15:0] b_req_wdata = '0, b_data_in = '0;
    logic        b_busy, b_done, b_data_oe, b_ncs, b_nwe, b_noe;
    logic [15:0] b_rdata, b_data_out;
    logic [11:0] b_addr;

    sram_bus_master u_dut (
        .clk(clk), .reset(reset), .req(req), .rnw(rnw), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .done(done), .rdata(rdata),
        .addr(addr), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
        .ncs(ncs), .nwe(nwe), .noe(noe)
    );

    sram_bus_master #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3)) u_dut2 (
        .clk(clk), .reset(reset), .req(b_req), .rnw(b_rnw), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .busy(b_busy), .done(b_done), .rdata(b_rdata),
        .addr(b_addr), .data_out(b_data_out), .data_oe(b_data_oe), .data_in(b_data_in),
        .ncs(b_ncs), .nwe(b_nwe), .noe(b_noe)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int done1, done2, ndone, nfall;
        logic prev_ncs;

        // Reset state, with req asserted alongside reset
        req = 1'b1; rnw = 1'b0; req_addr = 12'hABC; req_wdata = 16'hFFFF;
        tick(); tick();
        chk("rst_ncs", ncs, 1); chk("rst_nwe", nwe, 1); chk("rst_noe", noe, 1);
        chk("rst_oe", data_oe, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0); chk("rst_addr", addr, 0); chk("rst_dout", data_out, 0);
        reset = 1'b0; req = 1'b0;
        tick();
        chk("rst_req_ignored", {busy, ncs}, 2'b01);

        // Write 0xA5C3 to 0x123
        req = 1'b1; rnw = 1'b0; req_addr = 12'h123; req_wdata = 16'hA5C3;
        tick(); req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("wr_ncs_c%0d", c), ncs, 0);
            chk($sformatf("wr_nwe_c%0d", c), nwe, (c >= 2 && c <= 4) ? 1'b0 : 1'b1);
            chk($sformatf("wr_noe_c%0d", c), noe, 1);
            chk($sformatf("wr_oe_c%0d", c), data_oe, 1);
            chk($sformatf("wr_bus_c%0d", c), {addr, data_out}, {12'h123, 16'hA5C3});
            chk($sformatf("wr_busy_done_c%0d", c), {busy, done}, 2'b10);
            tick();
        end
        chk("wr_done", {done, busy, ncs, data_oe}, 4'b1010);
        chk("wr_rdata_kept", rdata, 0);
        tick();
        chk("wr_done_pulse", done, 0);

        // Read 0x7FF, data valid only during strobe
        req = 1'b1; rnw = 1'b1; req_addr = 12'h7FF; data_in = 16'hDEAD;
        tick(); req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            data_in = (c >= 2 && c <= 4) ? 16'h1234 : 16'hDEAD;
            chk($sformatf("rd_ncs_c%0d", c), ncs, 0);
            chk($sformatf("rd_noe_c%0d", c), noe, (c >= 2 && c <= 4) ? 1'b0 : 1'b1);
            chk($sformatf("rd_nwe_c%0d", c), nwe, 1);
            chk($sformatf("rd_oe_c%0d", c), data_oe, 0);
            chk($sformatf("rd_addr_c%0d", c), addr, 12'h7FF);
            if (c == 4) chk("rd_rdata_before", rdata, 0);
            tick();
        end
        chk("rd_done", {done, busy, ncs}, 3'b101);
        chk("rd_rdata", rdata, 16'h1234);
        tick();

        // Back-to-back write then read with req held high
        req = 1'b1; rnw = 1'b0; req_addr = 12'h010; req_wdata = 16'h0F0F;
        tick(); done1 = -1; done2 = -1;
        rnw = 1'b1; req_addr = 12'h020;
        for (int c = 1; c <= 12; c++) begin
            data_in = (c >= 8 && c <= 10) ? 16'h5A5A : 16'h0000;
            if (done) begin
                if (done1 < 0) done1 = c; else done2 = c;
            end
            if (c <= 5) chk($sformatf("b2b_wr_c%0d", c), {ncs, addr}, {1'b0, 12'h010});
            if (c == 6) chk("b2b_gap", {ncs, done}, 2'b11);
            if (c >= 7 && c <= 11) begin
                chk($sformatf("b2b_rd_c%0d", c), {ncs, addr}, {1'b0, 12'h020});
                chk($sformatf("b2b_noe_c%0d", c), noe, (c >= 8 && c <= 10) ? 1'b0 : 1'b1);
            end
            tick();
            if (c == 6) req = 1'b0;
        end
        if (done) done2 = 13;
        chk("b2b_done1", done1, 6);
        chk("b2b_done_gap", done2 - done1, 6);
        chk("b2b_rdata", rdata, 16'h5A5A);
        tick();

        // Reset during second STROBE cycle of a write
        req = 1'b1; rnw = 1'b0; req_addr = 12'h456; req_wdata = 16'h1111;
        tick(); req = 1'b0;
        tick(); tick();
        chk("abort_in_strobe", nwe, 0);
        reset = 1'b1;
        tick(); reset = 1'b0;
        chk("abort_strobes", {ncs, nwe, noe}, 3'b111);
        chk("abort_oe_busy", {data_oe, busy}, 2'b00);
        chk("abort_rdata", rdata, 0);
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) ndone++;
            tick();
        end
        chk("abort_no_done", ndone, 0);

        // Second req pulsed while busy is ignored
        req = 1'b1; rnw = 1'b0; req_addr = 12'h0AB; req_wdata = 16'h2222;
        tick(); req = 1'b0;
        ndone = 0; nfall = 0; prev_ncs = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            if (c == 2) begin req = 1'b1; req_addr = 12'h3AA; end
            if (c == 3) req = 1'b0;
            if (done) ndone++;
            if (prev_ncs && !ncs) nfall++;
            if (!ncs) chk($sformatf("ign_addr_c%0d", c), addr, 12'h0AB);
            prev_ncs = ncs;
            tick();
        end
        chk("ign_one_done", ndone, 1);
        chk("ign_one_cycle", nfall, 1);

        // Alternate timing: setup 2, strobe 1, hold 3 read
        b_req = 1'b1; b_rnw = 1'b1; b_req_addr = 12'h055; b_data_in = 16'h1111;
        tick(); b_req = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            b_data_in = (c == 3) ? 16'hBEEF : 16'h1111;
            if (c <= 6) begin
                chk($sformatf("alt_noe_c%0d", c), b_noe, (c == 3) ? 1'b0 : 1'b1);
                chk($sformatf("alt_ncs_done_c%0d", c), {b_ncs, b_done}, 2'b00);
            end else begin
                chk("alt_done", {b_done, b_busy, b_ncs}, 3'b101);
                chk("alt_rdata", b_rdata, 16'hBEEF);
            end
            tick();
        end
        chk("alt_done_pulse", b_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/sram_bus_master.md
SRAM_BUS_MASTER -- requirements
Module: sram_bus_master

Interface
REQ-001 Parameters SHALL be:
  DW, 15, data MSB index (bus width DW+1)
  AW, 11, address MSB index (bus width AW+1)
  SETUP_CYC, 1, address/CS-to-strobe cycles, legal 1..15
  STROBE_CYC, 3, nWE/nOE low cycles, legal 1..15
  HOLD_CYC, 1, strobe-high-to-CS-release cycles, legal 1..15
REQ-002 Ports SHALL be:
  clk  in  1  single clock; all logic on posedge
  reset  in  1  synchronous, active-high reset
  req  in  1  transaction request, sampled only when busy=0
  rnw  in  1  1=read, 0=write; sampled with req
  req_addr  in  AW+1  transaction address; sampled with req
  req_wdata  in  DW+1  write data; sampled with req
  busy  out  1  transaction in progress
  done  out  1  one-cycle completion pulse
  rdata  out  DW+1  last completed read data
  addr  out  AW+1  bus address
  data_out  out  DW+1  bus write data
  data_oe  out  1  tristate enable for data_out (pad logic external)
  data_in  in  DW+1  bus read data
  ncs  out  1  chip select, active low
  nwe  out  1  write strobe, active low
  noe  out  1  output enable, active low

Function
REQ-003 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-004 FSM states SHALL be IDLE, SETUP, STROBE, HOLD; a 4-bit down-counter SHALL time each non-IDLE state.
REQ-005 IDLE: ncs=nwe=noe=1, data_oe=0, busy=0; req=1 at an edge latches rnw/req_addr/req_wdata, enters SETUP, loads counter with SETUP_CYC.
REQ-006 req while busy=1 SHALL be ignored, without queuing.
REQ-007 SETUP: ncs=0, addr=latched address, nwe=noe=1, busy=1; data_oe=1 and data_out=latched data for writes; lasts exactly SETUP_CYC cycles, then STROBE.
REQ-008 STROBE: nwe=0 (write) or noe=0 (read), never both; lasts exactly STROBE_CYC cycles, then HOLD.
REQ-009 Read data SHALL be captured into rdata at the edge that ends the last STROBE cycle (data_in sampled while noe=0).
REQ-010 HOLD: nwe=noe=1, ncs=0, addr and (write) data_out/data_oe unchanged; lasts exactly HOLD_CYC cycles, then IDLE.
REQ-011 done SHALL be 1 for exactly the first IDLE cycle after HOLD, for reads and writes alike; busy=0 in that cycle.
REQ-012 Latency: req accepted at edge E0 -> done high during cycle after edge E0+SETUP_CYC+STROBE_CYC+HOLD_CYC (defaults: 5).
REQ-013 A req accepted in the done cycle SHALL start immediately; ncs SHALL therefore be high for exactly one cycle between back-to-back transactions.
REQ-014 addr/data_out SHALL stay stable from SETUP first cycle to HOLD last cycle; their value in IDLE is don't-care but SHALL hold last value.
REQ-015 rdata SHALL change only on read completion; writes leave it untouched.
REQ-016 ncs, nwe, noe SHALL be glitch-free, each changing at most once per state transition.

Reset
REQ-017 reset=1 at an edge SHALL force IDLE: ncs=nwe=noe=1, data_oe=0, busy=0, done=0, rdata=0, addr=0, data_out=0, counter=0.
REQ-018 reset during SETUP/STROBE/HOLD SHALL abort the transaction: no done pulse, rdata unchanged from reset value, strobes high at next cycle.
REQ-019 req asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-020 Write 0xA5C3 to 0x123, defaults -> ncs low 5 cycles, nwe low cycles 2-4, data_oe=1 for all 5, done one cycle later, noe never low.
REQ-021 Read 0x7FF, data_in=0x1234 during STROBE -> noe low 3 cycles, rdata=0x1234 in done cycle, nwe never low.
REQ-022 Back-to-back write then read, req held high -> ncs high exactly one cycle between, two done pulses 6 cycles apart.
REQ-023 reset pulsed during second STROBE cycle of a write -> strobes high, data_oe=0, busy=0 next cycle; no done.
REQ-024 Second req pulsed while busy -> ignored; exactly one bus cycle and one done.
REQ-025 SETUP_CYC=2, STROBE_CYC=1, HOLD_CYC=3 read -> done 6 cycles after accept, rdata sampled at single STROBE cycle.
